// File: rtl/sm_encoder.sv
// sm_encoder: two's-complement to sign-magnitude streaming converter.
// Two registered stages with valid/ready flow control, one word per cycle.
// The only unrepresentable input (-2^WIDTH) saturates to full-scale negative
// and is flagged on out_sat.
// Optional build macro SM_ENC_STATS_EN adds a saturating saturation-event
// counter (sat_count) with a synchronous clear (sat_clr).
module sm_encoder #(
  parameter int WIDTH = 31
`ifdef SM_ENC_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SM_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
`endif
);

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [WIDTH:0]   r_s1_mag;
  logic             r_out_valid;
  logic [WIDTH:0]   r_out_data;
  logic             r_out_sat;

  logic             w_advance;
  logic             w_sign;
  logic [WIDTH:0]   w_mag;
  logic [WIDTH:0]   w_s2_data;
  logic             w_s2_sat;

  // Both stages move together whenever the output slot is free or draining.
  assign w_advance = out_ready | ~r_out_valid;
  assign in_ready  = w_advance & rst_n;

  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign out_valid = r_out_valid;

  // Stage 1 combinational: split sign and form the WIDTH+1 bit magnitude.
  always_comb begin
    w_sign = in_data[WIDTH];
    w_mag  = in_data;
    if (w_sign) begin
      w_mag = (~in_data) + {{WIDTH{1'b0}}, 1'b1};
    end
  end

  // Stage 2 combinational: saturate -2^WIDTH and never emit negative zero.
  always_comb begin
    w_s2_data = {r_s1_sign, r_s1_mag[WIDTH-1:0]};
    w_s2_sat  = 1'b0;
    if (r_s1_mag[WIDTH]) begin
      w_s2_data = {(WIDTH+1){1'b1}};
      w_s2_sat  = 1'b1;
    end else if (r_s1_mag == '0) begin
      w_s2_data = '0;
    end
  end

  // Stage 1 register: capture sign and magnitude on every advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_mag   <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_sign  <= w_sign;
      r_s1_mag   <= w_mag;
    end
  end

  // Stage 2 register: output word, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      r_out_data  <= w_s2_data;
      r_out_sat   <= w_s2_sat;
    end
  end

`ifdef SM_ENC_STATS_EN
  logic [CNT_W-1:0] r_sat_count;
  logic             w_sat_xfer;

  assign w_sat_xfer = r_out_valid & out_ready & r_out_sat;
  assign sat_count  = r_sat_count;

  // Count saturated output transfers; sticks at full scale, clear has priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_count <= '0;
    end else if (sat_clr) begin
      r_sat_count <= '0;
    end else if (w_sat_xfer && (r_sat_count != {CNT_W{1'b1}})) begin
      r_sat_count <= r_sat_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_sm_encoder.sv
// tb_sm_encoder: scoreboard bench for sm_encoder at WIDTH=7 (CNT_W=4 when
// SM_ENC_STATS_EN is defined). Inputs change 1 ns after the rising edge;
// the monitor samples on the falling edge.
module tb_sm_encoder;
  localparam int W = 7;

  logic         clk;
  logic         rst_n;
  logic [W:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   out_data;
  logic         out_sat;
  logic         out_valid;
  logic         out_ready;
`ifdef SM_ENC_STATS_EN
  logic [3:0]   sat_count;
  logic         sat_clr;
  logic [3:0]   exp_cnt;
`endif

  int checks;
  int errors;
  logic [W+1:0] sb_q[$];

  sm_encoder #(
    .WIDTH(W)
`ifdef SM_ENC_STATS_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_sat(out_sat),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef SM_ENC_STATS_EN
    ,
    .sat_count(sat_count),
    .sat_clr(sat_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sign-magnitude word, sat flag} from the signed value.
  function automatic logic [W+1:0] model(input logic [W:0] x);
    int v;
    v = $signed(x);
    if (v == -128) return {8'hFF, 1'b1};
    if (v < 0) return {1'b1, 7'(-v), 1'b0};
    return {1'b0, x[W-1:0], 1'b0};
  endfunction

  // Scoreboard monitor: pop/compare on output transfers, push on input transfers.
  always @(negedge clk) begin
    logic [W+1:0] exp_w;
    if (!rst_n) begin
      sb_q.delete();
`ifdef SM_ENC_STATS_EN
      exp_cnt = 4'd0;
`endif
    end else begin
`ifdef SM_ENC_STATS_EN
      checks++;
      if (sat_count !== exp_cnt) begin
        errors++;
        $display("FAIL sat_count got %0d want %0d at %0t", sat_count, exp_cnt, $time);
      end
`endif
      exp_w = '0;
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got %h/%b want none at %0t", out_data, out_sat, $time);
        end else begin
          exp_w = sb_q.pop_front();
          if ({out_data, out_sat} !== exp_w) begin
            errors++;
            $display("FAIL sb_output got %h/%b want %h/%b at %0t",
                     out_data, out_sat, exp_w[W+1:1], exp_w[0], $time);
          end
        end
      end
`ifdef SM_ENC_STATS_EN
      if (sat_clr) exp_cnt = 4'd0;
      else if (out_valid && out_ready && exp_w[0] && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
`endif
      if (in_valid && in_ready) sb_q.push_back(model(in_data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef SM_ENC_STATS_EN
    sat_clr = 1'b0;
`endif
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 8'h00 || out_sat !== 1'b0) begin
      errors++; $display("FAIL rst_out_data got %h/%b want 00/0", out_data, out_sat);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
`ifdef SM_ENC_STATS_EN
    checks++;
    if (sat_count !== 4'd0) begin errors++; $display("FAIL rst_sat_count got %0d want 0", sat_count); end
`endif
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    in_data = 8'hFB; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h85 || out_sat !== 1'b0) begin
      errors++; $display("FAIL basic_lat2 got %b/%h/%b want 1/85/0", out_valid, out_data, out_sat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W:0] stim [4];
    stim[0] = 8'h00; stim[1] = 8'h7F; stim[2] = 8'h81; stim[3] = 8'h01;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = stim[i]; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1 idx %0d", in_ready, i); end
      tick();
      if (i >= 1) begin
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1 idx %0d", out_valid, i); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h01) begin
      errors++; $display("FAIL b2b_last got %b/%h want 1/01", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", out_valid); end
  endtask

  task automatic test_saturate();
    in_data = 8'h80; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hFF || out_sat !== 1'b1) begin
      errors++; $display("FAIL sat_word got %b/%h/%b want 1/FF/1", out_valid, out_data, out_sat);
    end
`ifdef SM_ENC_STATS_EN
    checks++;
    if (sat_count !== 4'd0) begin errors++; $display("FAIL sat_cnt_before got %0d want 0", sat_count); end
`endif
    tick();
`ifdef SM_ENC_STATS_EN
    checks++;
    if (sat_count !== 4'd1) begin errors++; $display("FAIL sat_cnt_after got %0d want 1", sat_count); end
`endif
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    in_data = 8'h03; in_valid = 1'b1;
    tick();
    in_data = 8'hFE;
    tick();
    in_data = 8'h10;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h03) begin
        errors++;
        $display("FAIL stall_hold got rdy %b vld %b data %h want 0/1/03 cyc %0d", in_ready, out_valid, out_data, i);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL stall_drain got %0d want 0 pending", sb_q.size()); end
  endtask

`ifdef SM_ENC_STATS_EN
  task automatic test_stats();
    out_ready = 1'b1;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    checks++;
    if (sat_count !== 4'd0) begin errors++; $display("FAIL stats_clr got %0d want 0", sat_count); end
    in_data = 8'h80; in_valid = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (sat_count !== 4'd15) begin errors++; $display("FAIL stats_sat15 got %0d want 15", sat_count); end
    in_data = 8'h80; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    sat_clr = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_sat !== 1'b1) begin
      errors++; $display("FAIL stats_clr_setup got %b/%b want 1/1", out_valid, out_sat);
    end
    tick();
    sat_clr = 1'b0;
    checks++;
    if (sat_count !== 4'd0) begin errors++; $display("FAIL stats_clr_wins got %0d want 0", sat_count); end
  endtask
`endif

  task automatic test_reset_flush();
    out_ready = 1'b1;
    in_data = 8'h05; in_valid = 1'b1;
    tick();
    in_data = 8'h06;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
    in_data = 8'h9C; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_ghost got %b want 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE4 || out_sat !== 1'b0) begin
      errors++; $display("FAIL flush_new got %b/%h/%b want 1/E4/0", out_valid, out_data, out_sat);
    end
    tick(); tick();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL flush_drain got %0d want 0 pending", sb_q.size()); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_saturate();
    test_stall();
`ifdef SM_ENC_STATS_EN
    test_stats();
`endif
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
